// File: rtl/mp_adder_cs.sv
// Two-stage pipelined carry-select adder/subtractor for wide unsigned operands.
// Optional feature macro: ADDER_PREDICTION_EN (early 16-bit segment-0 sum after one cycle).
module mp_adder_cs #(
    parameter int WIDTH = 1028,
    parameter int SEG   = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             subtract,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH:0]   result,
    output logic             out_valid
`ifdef ADDER_PREDICTION_EN
    ,
    output logic [15:0]      pred,
    output logic             pred_valid
`endif
);

    localparam int NSEG = (WIDTH + SEG - 1) / SEG;
    localparam int RW   = WIDTH + 1;
    // Top segment holds the remainder bits plus the carry/sign position at bit WIDTH.
    localparam int TOPW = RW - (NSEG - 1) * SEG;
    localparam int NC   = (NSEG > 1) ? NSEG - 1 : 1;

    logic [RW-1:0] a_ext;
    logic [RW-1:0] b_ext;

    logic [RW-1:0] sum0_d;
    logic [RW-1:0] sum1_d;
    logic [NC-1:0] c0_d;
    logic [NC-1:0] c1_d;

    logic [RW-1:0] s1_sum0;
    logic [RW-1:0] s1_sum1;
    logic [NC-1:0] s1_c0;
    logic [NC-1:0] s1_c1;
    logic          s1_valid;

    logic [NSEG-1:0] seg_carry;
    logic [RW-1:0]   sel_mask;
    logic [RW-1:0]   resolved;

    // Subtraction is a + ~b + 1 with ~b sign-extended with a 1 into bit WIDTH.
    assign a_ext = {1'b0, in_a};
    assign b_ext = subtract ? {1'b1, ~in_b} : {1'b0, in_b};

    for (genvar k = 0; k < NSEG; k++) begin : g_seg
        localparam int LO = k * SEG;

        if (k == NSEG - 1) begin : g_top
            logic [TOPW-1:0] opa;
            logic [TOPW-1:0] opb;

            assign opa = a_ext[LO +: TOPW];
            assign opb = b_ext[LO +: TOPW];

            // Carry out of the top segment lies beyond bit WIDTH and is dropped.
            if (k == 0) begin : g_single
                assign sum0_d[LO +: TOPW] = opa + opb + {{(TOPW-1){1'b0}}, subtract};
                assign sum1_d[LO +: TOPW] = sum0_d[LO +: TOPW];
            end else begin : g_pair
                assign sum0_d[LO +: TOPW] = opa + opb;
                assign sum1_d[LO +: TOPW] = opa + opb + {{(TOPW-1){1'b0}}, 1'b1};
            end

            assign sel_mask[LO +: TOPW] = {TOPW{seg_carry[k]}};
        end else begin : g_mid
            logic [SEG:0] t0;
            logic [SEG:0] t1;

            if (k == 0) begin : g_first
                assign t0 = {1'b0, a_ext[LO +: SEG]} + {1'b0, b_ext[LO +: SEG]}
                          + {{SEG{1'b0}}, subtract};
                assign t1 = t0;
            end else begin : g_other
                assign t0 = {1'b0, a_ext[LO +: SEG]} + {1'b0, b_ext[LO +: SEG]};
                assign t1 = {1'b0, a_ext[LO +: SEG]} + {1'b0, b_ext[LO +: SEG]}
                          + {{SEG{1'b0}}, 1'b1};
            end

            assign sum0_d[LO +: SEG] = t0[SEG-1:0];
            assign sum1_d[LO +: SEG] = t1[SEG-1:0];
            assign c0_d[k]           = t0[SEG];
            assign c1_d[k]           = t1[SEG];
            assign sel_mask[LO +: SEG] = {SEG{seg_carry[k]}};
        end
    end

    if (NSEG == 1) begin : g_no_chain
        assign c0_d = '0;
        assign c1_d = '0;
    end

    // Stage 1: pipeline valid bit.
    always_ff @(posedge clk) begin
        // NOTE: sequential state always uses non-blocking assignments so every
        // flop samples pre-edge values regardless of statement order.
        if (rst) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= in_valid;
        end
    end

    // Stage 1: datapath capture, qualified by s1_valid downstream.
    always_ff @(posedge clk) begin
        // NOTE: wide datapath registers carry no reset; the valid bits alone
        // decide whether their contents are meaningful.
        if (in_valid) begin
            s1_sum0 <= sum0_d;
            s1_sum1 <= sum1_d;
            s1_c0   <= c0_d;
            s1_c1   <= c1_d;
        end
    end

    // Stage 2: serial carry resolution across segments.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and a latch is never inferred.
        seg_carry = '0;
        for (int k = 1; k < NSEG; k++) begin
            seg_carry[k] = seg_carry[k-1] ? s1_c1[k-1] : s1_c0[k-1];
        end
    end

    assign resolved = (s1_sum1 & sel_mask) | (s1_sum0 & ~sel_mask);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            result    <= '0;
        end else begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                result <= resolved;
            end
        end
    end

`ifdef ADDER_PREDICTION_EN
    // Early look at the low 16 bits of segment 0, available one cycle after acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            pred       <= '0;
            pred_valid <= 1'b0;
        end else begin
            pred_valid <= in_valid;
            if (in_valid) begin
                pred <= sum0_d[15:0];
            end
        end
    end
`endif

endmodule
